bus_trace_capture: RTL

Bus-cycle trace capture for the emulated 6502 on the GODIL40_XC3S500E target. Sits directly downstream of `chip_6502`, in the `eclk` domain. On every falling edge of the model's `clk2out` (end of phi2) it samples address, data, `rw` and `sync` into a 26-bit record. After an arm/trigger sequence it buffers a fixed-length window of records in a FIFO, and a host-side reader drains that FIFO over a valid/ready handshake.

---
 rtl/godil_trace_pkg.sv | 33 +++
 rtl/trace_fifo.sv | 59 +++++
 rtl/bus_trace_capture.sv | 119 +++++++++++
 3 files changed

// File: rtl/godil_trace_pkg.sv
// Shared types and record layout for the 6502 bus-cycle trace capture.
// Record is {sync, rw, ab[15:0], data[7:0]}, MSB first.
package godil_trace_pkg;

    localparam int REC_W        = 26;
    localparam int REC_DATA_LSB = 0;
    localparam int REC_AB_LSB   = 8;
    localparam int REC_RW_BIT   = 24;
    localparam int REC_SYNC_BIT = 25;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } trace_state_t;

    function automatic logic [REC_W-1:0] pack_rec(
        input logic        sync,
        input logic        rw,
        input logic [15:0] ab,
        input logic [7:0]  data
    );
        logic [REC_W-1:0] r;
        r = '0;
        r[REC_SYNC_BIT]               = sync;
        r[REC_RW_BIT]                 = rw;
        r[REC_AB_LSB +: 16]           = ab;
        r[REC_DATA_LSB +: 8]          = data;
        return r;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Purpose: show-ahead FIFO with async clear and synchronous flush.
// Latency: a push into an empty FIFO is visible on head the next cycle.
// Backpressure: push while full is discarded unless a pop happens in the same cycle.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 26
) (
    input  logic         eclk,
    input  logic         ereset_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge eclk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bus_trace_capture.sv
// Purpose: samples 6502 bus cycles at the end of phi2 and buffers a triggered window.
// Latency: record visible on rec_data one eclk after the bus-edge cycle (FIFO empty).
// Backpressure: rec_valid/rec_ready; records arriving while full are dropped, overflow is sticky.
module bus_trace_capture
    import godil_trace_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int CAP_LEN = 64
) (
    input  logic             eclk,
    input  logic             ereset_n,
    input  logic             arm,
    input  logic             trig_en,
    input  logic [15:0]      trig_addr,
    input  logic [15:0]      ab,
    input  logic [7:0]       db_i,
    input  logic [7:0]       db_o,
    input  logic             rw,
    input  logic             sync,
    input  logic             clk2,
    output logic [REC_W-1:0] rec_data,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [1:0]       state,
    output logic             overflow,
    output logic             done
);

    localparam logic [15:0] CAP_LEN_W = 16'(CAP_LEN);

    trace_state_t     state_q;
    trace_state_t     state_nxt;
    logic [15:0]      cnt;
    logic [15:0]      cnt_nxt;
    logic             clk2_q;
    logic             be;
    logic             trig_hit;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [REC_W-1:0] rec_in;
    logic [REC_W-1:0] head;

    assign be       = clk2_q & ~clk2;
    assign trig_hit = ~trig_en | (ab == trig_addr);
    assign rec_in   = pack_rec(sync, rw, ab, rw ? db_i : db_o);

    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) clk2_q <= 1'b0;
        else           clk2_q <= clk2;
    end

    // arm wins over a coincident bus edge: the edge is neither stored nor counted.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt;
        push      = 1'b0;
        if (arm) begin
            state_nxt = ARMED;
            cnt_nxt   = '0;
        end else if (be) begin
            case (state_q)
                ARMED: begin
                    if (trig_hit) begin
                        push      = 1'b1;
                        cnt_nxt   = 16'd1;
                        state_nxt = (CAP_LEN_W == 16'd1) ? DONE : CAPTURE;
                    end
                end
                CAPTURE: begin
                    push    = 1'b1;
                    cnt_nxt = cnt + 16'd1;
                    if (cnt_nxt == CAP_LEN_W) state_nxt = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            state_q <= IDLE;
            cnt     <= '0;
        end else begin
            state_q <= state_nxt;
            cnt     <= cnt_nxt;
        end
    end

    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n)                   overflow <= 1'b0;
        else if (arm)                    overflow <= 1'b0;
        else if (push & fifo_full & ~pop) overflow <= 1'b1;
    end

    assign pop = rec_valid & rec_ready;

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .eclk      (eclk),
        .ereset_n  (ereset_n),
        .flush     (arm),
        .push      (push),
        .push_data (rec_in),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rec_valid = ~fifo_empty;
    assign rec_data  = rec_valid ? head : '0;
    assign state     = state_q;
    assign done      = (state_q == DONE);

endmodule
